lm_event_writer: RTL and testbench
==================================

Name: lm_event_writer

Overview:
- Producer side of the error/data FIFOs drained by the LED manager's decoders.
- Collects error-flag pulses from a source module (UART, CM) into a sticky pending vector.
- Writes the pending vector as one word into the downstream FIFO, respecting fifo_full.
- Enforces a hold-off gap between writes and counts flag events lost to coalescing.

Parameters:
WIDTH, 8, width of flag vector and FIFO word
HOLDOFF_CYCLES, 4, minimum idle cycles after each write before the next write (0 = back-to-back allowed)
CNT_W, 8, width of saturating lost-event counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
clear  input  1  synchronous clear of pending vector and lost_count
flags  input  WIDTH  error/event flag vector from source module
flags_valid  input  1  flags sampled this cycle when high
fifo_full  input  1  downstream FIFO cannot accept a write
wr_en  output  1  FIFO write strobe, one-cycle pulse, registered
wr_data  output  WIDTH  FIFO write word, registered, valid while wr_en=1
busy  output  1  high when state is HOLDOFF or pending is nonzero
lost_count  output  CNT_W  saturating count of lost flag events

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, pending=0, wr_en=0, wr_data=0, holdoff counter=0, lost_count=0, busy=0.
- All state is updated on the rising edge of clk; all outputs are registered except busy, which is combinational from state and pending.
- Pending update each cycle:
  - Default: pending <= pending | (flags_valid ? flags : 0).
  - On a write edge: pending <= (flags_valid ? flags : 0). Flags arriving in the write cycle go to the next word and are never lost.
- State machine, states IDLE and HOLDOFF:
  - IDLE with pending!=0 and fifo_full=0 (write edge):
    - wr_en<=1, wr_data<=pending (value before this edge).
    - If HOLDOFF_CYCLES>0: state<=HOLDOFF, counter<=HOLDOFF_CYCLES-1.
    - If HOLDOFF_CYCLES=0: stay in IDLE.
  - IDLE with pending=0 or fifo_full=1: wr_en<=0, no state change. Pending keeps accumulating while the FIFO is full.
  - HOLDOFF: wr_en<=0 on the first HOLDOFF cycle. Counter decrements each cycle; at counter=0, state<=IDLE. No write occurs in HOLDOFF regardless of fifo_full.
- Timing:
  - wr_en is high exactly one cycle per write.
  - Consecutive wr_en pulses are separated by at least HOLDOFF_CYCLES low cycles.
  - Latency from first flags_valid (FIFO empty, IDLE, pending=0) to wr_en=1 is 2 cycles: capture edge, then write edge.
- wr_data holds its last value when wr_en=0.
- Lost events:
  - lost_count increments by 1 on an edge where flags_valid=1, (flags & pending)!=0, and the edge is not a write edge.
  - Increments at most once per cycle; saturates at 2^CNT_W-1 with no wrap.
- clear=1:
  - pending<=0 and lost_count<=0; clear has priority over flag capture and over lost_count increment.
  - Blocks a write on that edge.
  - State and counter are unaffected, so an in-progress HOLDOFF completes.
- fifo_full changing mid-HOLDOFF has no effect until the return to IDLE.
- Reset asserted mid-HOLDOFF or with pending!=0: everything returns to reset values immediately, with no write. After reset deassertion, behaviour is as from power-up.

Test Plan:
- Reset, then flags=0x05 with flags_valid for 1 cycle, fifo_full=0 -> wr_en=1 exactly one cycle, 2 cycles later, wr_data=0x05. Then wr_en=0 for ≥4 cycles; busy=0 after HOLDOFF ends.
- fifo_full=1; pulse flags 0x01, 0x02, 0x80 on separate cycles; release fifo_full -> single write wr_data=0x83, lost_count=0.
- fifo_full=1; pulse 0x04 twice -> lost_count=1. Release -> one write of 0x04.
- flags=0x10 presented exactly on a write edge of pending 0x01 -> first write 0x01, second write 0x10 after 4 HOLDOFF cycles, lost_count=0.
- CNT_W=2; generate 5 overlapping lost events -> lost_count=3 (saturated). Assert clear -> lost_count=0, pending=0, no wr_en.
- Assert rst mid-HOLDOFF with pending=0x20 -> wr_en=0, wr_data=0, lost_count=0, busy=0 immediately. No write after deassertion until new flags arrive.

Source files
------------

// File: rtl/lm_event_writer_if.sv
// lm_event_writer_if: bundles the flag-source inputs and the FIFO write port of
// lm_event_writer.
//   flags       - error/event flag vector from the source module
//   flags_valid - flags are sampled in cycles where this is high
//   fifo_full   - downstream FIFO cannot accept a write
//   wr_en       - FIFO write strobe, one-cycle pulse
//   wr_data     - FIFO write word, valid while wr_en is high
// Modport master is the writer; slave is the source/FIFO side.
interface lm_event_writer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] flags;
  logic             flags_valid;
  logic             fifo_full;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;

  modport master (
    input  flags,
    input  flags_valid,
    input  fifo_full,
    output wr_en,
    output wr_data
  );

  modport slave (
    output flags,
    output flags_valid,
    output fifo_full,
    input  wr_en,
    input  wr_data
  );
endinterface

// File: rtl/lm_event_writer.sv
// lm_event_writer: producer side of the LED manager's error/data FIFOs.
// Error-flag pulses are accumulated into a sticky pending vector, which is
// written out as a single FIFO word when the FIFO has room. After each write
// the block idles for HOLDOFF_CYCLES cycles before it may write again. Flag
// bits that arrive while the same bit is already pending are coalesced, and
// each such cycle bumps a saturating lost-event counter.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   clear      - synchronous clear of pending vector and lost_count
//   bus        - flags/flags_valid/fifo_full in, wr_en/wr_data out (registered)
//   busy       - high while in hold-off or while anything is pending
//   lost_count - saturating count of flag events lost to coalescing
module lm_event_writer #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned HOLDOFF_CYCLES = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  lm_event_writer_if.master    bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     lost_count
);

  // Hold-off counter only ever holds 0 .. HOLDOFF_CYCLES-1.
  localparam int unsigned HoldW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldInit =
      (HOLDOFF_CYCLES > 0) ? HoldW'(HOLDOFF_CYCLES - 1) : '0;

  typedef enum logic [0:0] {StIdle, StHoldoff} state_e;

  state_e           state_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic [WIDTH-1:0] pending_q;
  logic [CNT_W-1:0] lost_q;
  logic             wr_en_q;
  logic [WIDTH-1:0] wr_data_q;

  logic [WIDTH-1:0] flag_in;
  logic             write_edge;
  logic             lost_hit;

  always_comb begin
    flag_in    = bus.flags_valid ? bus.flags : '0;
    // clear wins over a write so that a cleared vector is never emitted.
    write_edge = (state_q == StIdle) && (|pending_q) && !bus.fifo_full && !clear;
    // A flag that lands on a write edge goes into the fresh vector, so it is
    // never counted as lost.
    lost_hit   = bus.flags_valid && (|(bus.flags & pending_q)) && !write_edge;
    busy       = (state_q == StHoldoff) || (|pending_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      pending_q  <= '0;
      lost_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      if (clear) begin
        pending_q <= '0;
      end else if (write_edge) begin
        pending_q <= flag_in;
      end else begin
        pending_q <= pending_q | flag_in;
      end

      if (clear) begin
        lost_q <= '0;
      end else if (lost_hit && (lost_q != {CNT_W{1'b1}})) begin
        lost_q <= lost_q + 1'b1;
      end

      // State and counter ignore clear so an in-progress hold-off completes.
      unique case (state_q)
        StIdle: begin
          if (write_edge) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= pending_q;
            if (HOLDOFF_CYCLES > 0) begin
              state_q    <= StHoldoff;
              hold_cnt_q <= HoldInit;
            end
          end else begin
            wr_en_q <= 1'b0;
          end
        end
        StHoldoff: begin
          wr_en_q <= 1'b0;
          if (hold_cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_data = wr_data_q;
  assign lost_count  = lost_q;

endmodule

// File: tb/tb_lm_event_writer.sv
// Directed bench for lm_event_writer with a write scoreboard: expected words are
// queued as stimulus is driven, and words seen on the FIFO port are compared
// against them in order.
module tb_lm_event_writer;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             busy;
  logic [CNT_W-1:0] lost_count;

  lm_event_writer_if #(.WIDTH(WIDTH)) bus ();

  lm_event_writer #(
    .WIDTH         (WIDTH),
    .HOLDOFF_CYCLES(HOLD),
    .CNT_W         (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .bus       (bus),
    .busy      (busy),
    .lost_count(lost_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] obs_q[$];
  int unsigned      obs_cyc[$];

  // Every cycle with wr_en high is one observed write.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      obs_q.push_back(bus.wr_data);
      obs_cyc.push_back(cyc);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [WIDTH-1:0] f);
    bus.flags       = f;
    bus.flags_valid = 1'b1;
    tick(1);
    bus.flags_valid = 1'b0;
    bus.flags       = '0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, " write count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, " wr_data"}, obs_q.pop_front(), exp_q.pop_front());
    end
    obs_q.delete();
    exp_q.delete();
    obs_cyc.delete();
  endtask

  initial begin
    rst             = 1'b0;
    clear           = 1'b0;
    bus.flags       = '0;
    bus.flags_valid = 1'b0;
    bus.fifo_full   = 1'b0;
    tick(2);
    check("rst wr_en", bus.wr_en, 0);
    check("rst wr_data", bus.wr_data, 0);
    check("rst busy", busy, 0);
    check("rst lost_count", lost_count, 0);
    rst = 1'b1;
    tick(2);

    // Single event: capture edge, then write edge, then hold-off.
    exp_q.push_back(8'h05);
    pulse(8'h05);
    check("t1 wr_en after capture", bus.wr_en, 0);
    check("t1 busy pending", busy, 1);
    tick(1);
    check("t1 wr_en", bus.wr_en, 1);
    check("t1 wr_data", bus.wr_data, 8'h05);
    tick(1);
    check("t1 wr_en one cycle", bus.wr_en, 0);
    check("t1 wr_data held", bus.wr_data, 8'h05);
    tick(2);
    check("t1 busy in holdoff", busy, 1);
    tick(1);
    check("t1 busy after holdoff", busy, 0);
    check_writes("t1");

    // Accumulate while full, single merged write on release.
    bus.fifo_full = 1'b1;
    pulse(8'h01);
    pulse(8'h02);
    pulse(8'h80);
    tick(2);
    check("t2 busy while full", busy, 1);
    check("t2 lost_count", lost_count, 0);
    check("t2 no write while full", obs_q.size(), 0);
    exp_q.push_back(8'h83);
    bus.fifo_full = 1'b0;
    tick(1);
    check("t2 wr_en", bus.wr_en, 1);
    tick(5);
    check_writes("t2");

    // Same bit twice while full counts one lost event.
    bus.fifo_full = 1'b1;
    pulse(8'h04);
    pulse(8'h04);
    check("t3 lost_count", lost_count, 1);
    tick(1);
    exp_q.push_back(8'h04);
    bus.fifo_full = 1'b0;
    tick(6);
    check_writes("t3");

    // Flag arriving on the write edge rolls into the next word.
    bus.flags       = 8'h01;
    bus.flags_valid = 1'b1;
    tick(1);
    bus.flags       = 8'h10;
    tick(1);
    bus.flags_valid = 1'b0;
    bus.flags       = '0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h10);
    check("t4 first wr_en", bus.wr_en, 1);
    check("t4 first wr_data", bus.wr_data, 8'h01);
    tick(4);
    check("t4 wr_en low at gap end", bus.wr_en, 0);
    tick(1);
    check("t4 second wr_en", bus.wr_en, 1);
    check("t4 second wr_data", bus.wr_data, 8'h10);
    tick(1);
    if (obs_cyc.size() == 2) begin
      check("t4 write spacing", obs_cyc[1] - obs_cyc[0], HOLD + 1);
    end
    check("t4 lost_count unchanged", lost_count, 1);
    tick(4);
    check_writes("t4");

    // Saturation, then clear blocks the write and zeroes everything.
    bus.fifo_full = 1'b1;
    repeat (6) pulse(8'h08);
    check("t5 lost_count saturated", lost_count, 3);
    check("t5 busy", busy, 1);
    clear         = 1'b1;
    bus.fifo_full = 1'b0;
    tick(1);
    clear = 1'b0;
    check("t5 clear lost_count", lost_count, 0);
    check("t5 clear wr_en", bus.wr_en, 0);
    check("t5 clear busy", busy, 0);
    tick(6);
    check_writes("t5");

    // Reset right after a write, with 0x20 pending and a lost event counted.
    bus.fifo_full = 1'b1;
    pulse(8'h40);
    pulse(8'h40);
    check("t6 lost_count", lost_count, 1);
    bus.fifo_full   = 1'b0;
    bus.flags       = 8'h20;
    bus.flags_valid = 1'b1;
    tick(1);
    bus.flags_valid = 1'b0;
    bus.flags       = '0;
    check("t6 wr_en", bus.wr_en, 1);
    check("t6 wr_data", bus.wr_data, 8'h40);
    rst = 1'b0;
    #1;
    check("t6 rst wr_en", bus.wr_en, 0);
    check("t6 rst wr_data", bus.wr_data, 0);
    check("t6 rst lost_count", lost_count, 0);
    check("t6 rst busy", busy, 0);
    tick(2);
    rst = 1'b1;
    tick(8);
    check("t6 idle after reset", busy, 0);
    check_writes("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
